// File: rtl/display_scheduler.sv
// display_scheduler
//   Time-shares one 8-digit seven-segment display between four result
//   producers. Each producer loads a 32-bit word into its own hold buffer.
//   The scheduler rotates through the valid buffers on a millisecond-based
//   dwell timer, and also supports manual advance and freezing the rotation.
//
// Ports
//   clk        in   1    system clock
//   rst        in   1    synchronous reset, active-high
//   ld         in   4    per-channel load strobe; ld[i] captures channel i word
//   ld_data    in   128  channel i word at ld_data[32*i+31:32*i]
//   next       in   1    single-cycle pulse: advance to the next valid channel
//   hold       in   1    level: freeze auto-rotation (next still works)
//   clr        in   1    single-cycle pulse: invalidate and zero all channels
//   disp_data  out  32   word currently shown
//   disp_en    out  1    display enable; high while any channel is valid
//   cur_ch     out  2    index of the channel currently selected
//   ch_valid   out  4    per-channel valid flags
module display_scheduler #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int DWELL_MS      = 1000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   ld,
  input  logic [127:0] ld_data,
  input  logic         next,
  input  logic         hold,
  input  logic         clr,
  output logic [31:0]  disp_data,
  output logic         disp_en,
  output logic [1:0]   cur_ch,
  output logic [3:0]   ch_valid
);

  localparam int TICK_CYCLES = (CLK_FREQUENCY / 1000 < 1) ? 1 : CLK_FREQUENCY / 1000;
  localparam int MS_W        = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int DWELL_N     = (DWELL_MS < 1) ? 1 : DWELL_MS;
  localparam int DW_W        = (DWELL_N > 1) ? $clog2(DWELL_N) : 1;

  localparam logic [MS_W-1:0] MS_LAST    = MS_W'(TICK_CYCLES - 1);
  localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL_N - 1);

  logic [MS_W-1:0] ms_cnt;
  logic [DW_W-1:0] dwell_cnt;
  logic [31:0]     word_q [4];

  logic            tick;
  logic            auto_adv;
  logic            advance;
  logic            empty_jump;
  logic [1:0]      adv_ch;
  logic [1:0]      cand;
  logic            found;
  logic [1:0]      ld_low;

  logic [MS_W-1:0] ms_cnt_d;
  logic [DW_W-1:0] dwell_cnt_d;
  logic [1:0]      cur_ch_d;
  logic [3:0]      ch_valid_d;

  assign tick       = (ms_cnt == MS_LAST);
  assign auto_adv   = tick && !hold && (dwell_cnt == DWELL_LAST);
  // next and an expiring dwell in the same cycle still give a single step
  assign advance    = next || auto_adv;
  assign empty_jump = (ch_valid == 4'b0000) && (ld != 4'b0000);

  // Next valid channel after cur_ch, using pre-load valid flags
  always_comb begin
    adv_ch = cur_ch;
    found  = 1'b0;
    cand   = cur_ch;
    for (int k = 1; k < 4; k++) begin
      cand = cur_ch + 2'(k);
      if (!found && ch_valid[cand]) begin
        adv_ch = cand;
        found  = 1'b1;
      end
    end
  end

  always_comb begin
    ld_low = 2'd0;
    if (ld[0])      ld_low = 2'd0;
    else if (ld[1]) ld_low = 2'd1;
    else if (ld[2]) ld_low = 2'd2;
    else if (ld[3]) ld_low = 2'd3;
  end

  always_comb begin
    ms_cnt_d    = tick ? '0 : ms_cnt + 1'b1;
    dwell_cnt_d = dwell_cnt;
    cur_ch_d    = cur_ch;
    ch_valid_d  = ch_valid | ld;

    if (tick && !hold)
      dwell_cnt_d = (dwell_cnt == DWELL_LAST) ? '0 : dwell_cnt + 1'b1;

    if (clr) begin
      ch_valid_d  = 4'b0000;
      cur_ch_d    = 2'd0;
      dwell_cnt_d = '0;
    end else if (empty_jump) begin
      cur_ch_d    = ld_low;
      dwell_cnt_d = '0;
    end else begin
      if (advance)
        cur_ch_d = adv_ch;
      if (next)
        dwell_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ms_cnt    <= '0;
      dwell_cnt <= '0;
      cur_ch    <= 2'd0;
      ch_valid  <= 4'b0000;
      disp_data <= 32'h0;
      disp_en   <= 1'b0;
      for (int i = 0; i < 4; i++)
        word_q[i] <= 32'h0;
    end else begin
      ms_cnt    <= ms_cnt_d;
      dwell_cnt <= dwell_cnt_d;
      cur_ch    <= cur_ch_d;
      ch_valid  <= ch_valid_d;
      // display path follows the state as it was before this edge
      disp_data <= word_q[cur_ch];
      disp_en   <= |ch_valid;
      for (int i = 0; i < 4; i++) begin
        if (clr)
          word_q[i] <= 32'h0;
        else if (ld[i])
          word_q[i] <= ld_data[32*i +: 32];
      end
    end
  end

endmodule

// File: tb/tb_display_scheduler.sv
// tb_display_scheduler
//   Directed bench for display_scheduler with a 4-cycle ms tick and a
//   3-tick dwell. Edge numbers below count clk edges after the last reset
//   edge; ticks fall on edges 4, 8, 12, ... so an undisturbed dwell
//   expires on edges 12, 24, 36, ...
module tb_display_scheduler;

  logic         clk;
  logic         rst;
  logic [3:0]   ld;
  logic [127:0] ld_data;
  logic         next;
  logic         hold;
  logic         clr;
  logic [31:0]  disp_data;
  logic         disp_en;
  logic [1:0]   cur_ch;
  logic [3:0]   ch_valid;

  int vectors = 0;
  int errors  = 0;
  int ecount  = 0;

  display_scheduler #(
    .CLK_FREQUENCY (4000),
    .DWELL_MS      (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .ld_data   (ld_data),
    .next      (next),
    .hold      (hold),
    .clr       (clr),
    .disp_data (disp_data),
    .disp_en   (disp_en),
    .cur_ch    (cur_ch),
    .ch_valid  (ch_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    ecount = 0;
  endtask

  task automatic adv_to(input int e);
    while (ecount < e) begin
      @(posedge clk);
      #1;
      ecount++;
    end
  endtask

  initial begin
    rst     = 1'b0;
    ld      = 4'b0000;
    ld_data = '0;
    next    = 1'b0;
    hold    = 1'b0;
    clr     = 1'b0;

    // reset state
    do_reset();
    chk("rst_cur",   32'(cur_ch),    32'd0);
    chk("rst_valid", 32'(ch_valid),  32'd0);
    chk("rst_data",  disp_data,      32'h0);
    chk("rst_en",    32'(disp_en),   32'd0);

    // 1: empty jump on single load
    ld      = 4'b0100;
    ld_data = {32'h0, 32'h1234_5678, 32'h0, 32'h0};
    adv_to(1);
    ld = 4'b0000;
    chk("t1_cur",   32'(cur_ch),   32'd2);
    chk("t1_valid", 32'(ch_valid), 32'h4);
    chk("t1_en_e1", 32'(disp_en),  32'd0);
    adv_to(2);
    chk("t1_data",  disp_data,     32'h1234_5678);
    chk("t1_en",    32'(disp_en),  32'd1);

    // 2: rotation over channels 0,1,3
    do_reset();
    ld      = 4'b1011;
    ld_data = {32'h3333_0003, 32'h2222_0002, 32'h1111_0001, 32'h0000_AAAA};
    adv_to(1);
    ld = 4'b0000;
    chk("t2_cur_e1",  32'(cur_ch),   32'd0);
    chk("t2_valid",   32'(ch_valid), 32'hB);
    adv_to(11);
    chk("t2_cur_e11", 32'(cur_ch),   32'd0);
    adv_to(12);
    chk("t2_cur_e12", 32'(cur_ch),   32'd1);
    adv_to(13);
    chk("t2_data_e13", disp_data,    32'h1111_0001);
    adv_to(23);
    chk("t2_cur_e23", 32'(cur_ch),   32'd1);
    adv_to(24);
    chk("t2_cur_e24", 32'(cur_ch),   32'd3);
    adv_to(25);
    chk("t2_data_e25", disp_data,    32'h3333_0003);
    adv_to(36);
    chk("t2_cur_e36", 32'(cur_ch),   32'd0);

    // 3: hold freezes rotation and dwell; next still advances
    adv_to(44);
    chk("t3_dwell_e44", 32'(dut.dwell_cnt), 32'd2);
    hold = 1'b1;
    adv_to(60);
    chk("t3_cur_e60", 32'(cur_ch), 32'd0);
    adv_to(84);
    chk("t3_cur_e84",   32'(cur_ch),        32'd0);
    chk("t3_dwell_e84", 32'(dut.dwell_cnt), 32'd2);
    next = 1'b1;
    adv_to(85);
    next = 1'b0;
    hold = 1'b0;
    chk("t3_cur_next",   32'(cur_ch),        32'd1);
    chk("t3_dwell_next", 32'(dut.dwell_cnt), 32'd0);

    // 4: next coincides with dwell expiry at edge 96
    adv_to(95);
    chk("t4_cur_e95", 32'(cur_ch), 32'd1);
    next = 1'b1;
    adv_to(96);
    next = 1'b0;
    chk("t4_cur_e96",   32'(cur_ch),        32'd3);
    chk("t4_dwell_e96", 32'(dut.dwell_cnt), 32'd0);
    adv_to(97);
    chk("t4_cur_e97", 32'(cur_ch), 32'd3);

    // 5: clr beats a simultaneous load
    clr     = 1'b1;
    ld      = 4'b0001;
    ld_data = {32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF};
    adv_to(98);
    clr = 1'b0;
    ld  = 4'b0000;
    chk("t5_valid_e98", 32'(ch_valid), 32'd0);
    chk("t5_cur_e98",   32'(cur_ch),   32'd0);
    adv_to(99);
    chk("t5_en",   32'(disp_en), 32'd0);
    chk("t5_data", disp_data,    32'h0);

    // 6: lone valid channel ignores next; reset mid-dwell
    ld      = 4'b0100;
    ld_data = {32'h0, 32'hAABB_CCDD, 32'h0, 32'h0};
    adv_to(100);
    ld   = 4'b0000;
    next = 1'b1;
    adv_to(101);
    next = 1'b0;
    chk("t6_cur_next", 32'(cur_ch), 32'd2);
    adv_to(102);
    chk("t6_data", disp_data, 32'hAABB_CCDD);
    adv_to(105);
    chk("t6_dwell_mid", 32'(dut.dwell_cnt), 32'd1);
    rst = 1'b1;
    adv_to(106);
    rst = 1'b0;
    chk("t6_rst_cur",   32'(cur_ch),        32'd0);
    chk("t6_rst_valid", 32'(ch_valid),      32'd0);
    chk("t6_rst_data",  disp_data,          32'h0);
    chk("t6_rst_en",    32'(disp_en),       32'd0);
    chk("t6_rst_dwell", 32'(dut.dwell_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
